// File: rtl/piece_queue_if.sv
// Handshake bundle between the piece generator, the game controller
// and the piece queue.
interface piece_queue_if;
   logic       gen_ready;
   logic [2:0] gen_piece;
   logic       req;
   logic       piece_valid;
   logic [2:0] piece_out;
   logic [2:0] preview;
   logic       preview_valid;
   logic [3:0] count;
   logic       full;

   modport master (
      output gen_ready, gen_piece, req,
      input  piece_valid, piece_out, preview,
      input  preview_valid, count, full
   );

   modport slave (
      input  gen_ready, gen_piece, req,
      output piece_valid, piece_out, preview,
      output preview_valid, count, full
   );
endinterface

// File: rtl/piece_queue.sv
// Circular queue of upcoming pieces with a repeat filter and a
// two-state grant controller that can wait for an empty queue to fill.
module piece_queue #(
   parameter int DEPTH     = 4,
   parameter int NO_REPEAT = 1
) (
   input  logic          clk,
   input  logic          nreset,
   piece_queue_if.slave  pq
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {IDLE, WAIT} state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   wr_q, wr_d;
   logic [AW-1:0]   rd_q, rd_d;
   logic [3:0]      count_q, count_d;
   logic [2:0]      last_q, last_d;
   logic            pv_q, pv_d;
   logic [2:0]      out_q, out_d;
   logic [2:0]      mem_q [DEPTH];
   logic            push, pop;

   // Pop only from registered occupancy, so an empty-queue push is
   // never forwarded to the consumer in the same cycle.
   always_comb begin
      pop  = (count_q != 4'd0) &&
             ((state_q == IDLE && pq.req) || state_q == WAIT);
      push = pq.gen_ready && (pq.gen_piece != 3'd7) &&
             ((count_q < 4'(DEPTH)) || pop) &&
             !((NO_REPEAT != 0) && (pq.gen_piece == last_q));
   end

   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      last_d  = last_q;
      pv_d    = pop;
      out_d   = out_q;
      unique case (state_q)
         IDLE: if (pq.req && count_q == 4'd0) state_d = WAIT;
         WAIT: if (count_q != 4'd0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (push) begin
         wr_d   = wr_q + 1'b1;
         last_d = pq.gen_piece;
      end
      if (pop) begin
         rd_d  = rd_q + 1'b1;
         out_d = mem_q[rd_q];
      end
      if (push && !pop)      count_d = count_q + 4'd1;
      else if (pop && !push) count_d = count_q - 4'd1;
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q <= IDLE;
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         last_q  <= 3'd7;
         pv_q    <= 1'b0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
         last_q  <= last_d;
         pv_q    <= pv_d;
         out_q   <= out_d;
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push) begin
         mem_q[wr_q] <= pq.gen_piece;
      end
   end

   assign pq.piece_valid   = pv_q;
   assign pq.piece_out     = out_q;
   assign pq.preview       = mem_q[rd_q];
   assign pq.preview_valid = (count_q != 4'd0);
   assign pq.count         = count_q;
   assign pq.full          = (count_q == 4'(DEPTH));

endmodule

// File: tb/tb_piece_queue.sv
// Directed bench for piece_queue: default instance plus a second
// instance with the repeat filter disabled, sharing the same stimulus.
module tb_piece_queue;

   logic clk = 1'b0;
   logic nreset = 1'b0;
   int   errors = 0;
   int   checks = 0;

   piece_queue_if a ();
   piece_queue_if b ();

   assign b.gen_ready = a.gen_ready;
   assign b.gen_piece = a.gen_piece;
   assign b.req       = a.req;

   piece_queue #(.DEPTH(4), .NO_REPEAT(1)) dut_a (
      .clk(clk), .nreset(nreset), .pq(a)
   );
   piece_queue #(.DEPTH(4), .NO_REPEAT(0)) dut_b (
      .clk(clk), .nreset(nreset), .pq(b)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      a.gen_ready = 1'b0;
      a.gen_piece = 3'd0;
      a.req       = 1'b0;
      nreset      = 1'b0;
      #3;
      @(negedge clk);
      nreset = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++;
      if (a.count !== 4'd0) begin
         errors++; $display("FAIL rst_count got %0d want 0", a.count);
      end
      checks++;
      if (a.piece_valid !== 1'b0 || a.piece_out !== 3'd0) begin
         errors++;
         $display("FAIL rst_out got v=%b p=%0d want v=0 p=0",
                  a.piece_valid, a.piece_out);
      end
      checks++;
      if (a.preview !== 3'd0 || a.preview_valid !== 1'b0 ||
          a.full !== 1'b0) begin
         errors++;
         $display("FAIL rst_prev got p=%0d pv=%b f=%b want 0 0 0",
                  a.preview, a.preview_valid, a.full);
      end
   endtask

   task automatic test_fill();
      logic [2:0] seq [4] = '{3'd3, 3'd5, 3'd1, 3'd6};
      do_reset();
      a.gen_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a.gen_piece = seq[i];
         step();
         checks++;
         if (a.count !== 4'(i + 1)) begin
            errors++;
            $display("FAIL fill_count%0d got %0d want %0d",
                     i, a.count, i + 1);
         end
      end
      checks++;
      if (a.full !== 1'b1 || a.preview !== 3'd3) begin
         errors++;
         $display("FAIL fill_full got f=%b p=%0d want f=1 p=3",
                  a.full, a.preview);
      end
      a.gen_piece = 3'd2;
      step();
      checks++;
      if (a.count !== 4'd4 || a.piece_valid !== 1'b0) begin
         errors++;
         $display("FAIL fill_reject got c=%0d v=%b want c=4 v=0",
                  a.count, a.piece_valid);
      end
   endtask

   // Runs straight after test_fill: queue holds 3,5,1,6.
   task automatic test_full_push_pop();
      logic [2:0] tail [4] = '{3'd5, 3'd1, 3'd6, 3'd2};
      a.req       = 1'b1;
      a.gen_ready = 1'b1;
      a.gen_piece = 3'd2;
      step();
      checks++;
      if (a.piece_valid !== 1'b1 || a.piece_out !== 3'd3 ||
          a.count !== 4'd4 || a.preview !== 3'd5) begin
         errors++;
         $display("FAIL pp_grant got v=%b p=%0d c=%0d pr=%0d want 1 3 4 5",
                  a.piece_valid, a.piece_out, a.count, a.preview);
      end
      a.gen_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (a.piece_valid !== 1'b1 || a.piece_out !== tail[i] ||
             a.count !== 4'(3 - i)) begin
            errors++;
            $display("FAIL pp_drain%0d got v=%b p=%0d c=%0d want 1 %0d %0d",
                     i, a.piece_valid, a.piece_out, a.count, tail[i], 3 - i);
         end
      end
      a.req = 1'b0;
      step();
      checks++;
      if (a.piece_valid !== 1'b0 || a.piece_out !== 3'd2 ||
          a.preview_valid !== 1'b0) begin
         errors++;
         $display("FAIL pp_idle got v=%b p=%0d pv=%b want 0 2 0",
                  a.piece_valid, a.piece_out, a.preview_valid);
      end
   endtask

   task automatic test_repeat();
      do_reset();
      a.gen_ready = 1'b1;
      a.gen_piece = 3'd4; step();
      a.gen_piece = 3'd4; step();
      a.gen_piece = 3'd2; step();
      a.gen_ready = 1'b0;
      checks++;
      if (a.count !== 4'd2 || a.preview !== 3'd4) begin
         errors++;
         $display("FAIL rep_filter got c=%0d p=%0d want c=2 p=4",
                  a.count, a.preview);
      end
      checks++;
      if (b.count !== 4'd3) begin
         errors++; $display("FAIL rep_nofilter got %0d want 3", b.count);
      end
   endtask

   task automatic test_illegal();
      do_reset();
      a.gen_ready = 1'b1;
      a.gen_piece = 3'd7;
      for (int i = 0; i < 10; i++) step();
      a.gen_ready = 1'b0;
      checks++;
      if (a.count !== 4'd0 || a.preview_valid !== 1'b0 ||
          a.piece_valid !== 1'b0 || b.count !== 4'd0) begin
         errors++;
         $display("FAIL illegal got c=%0d pv=%b v=%b cb=%0d want 0",
                  a.count, a.preview_valid, a.piece_valid, b.count);
      end
   endtask

   task automatic test_empty_req();
      do_reset();
      a.req = 1'b1;
      step();
      step();
      a.req = 1'b0;
      checks++;
      if (a.piece_valid !== 1'b0 || a.count !== 4'd0) begin
         errors++;
         $display("FAIL er_wait got v=%b c=%0d want v=0 c=0",
                  a.piece_valid, a.count);
      end
      a.gen_ready = 1'b1;
      a.gen_piece = 3'd6;
      step();
      a.gen_ready = 1'b0;
      checks++;
      if (a.count !== 4'd1 || a.piece_valid !== 1'b0) begin
         errors++;
         $display("FAIL er_push got c=%0d v=%b want c=1 v=0",
                  a.count, a.piece_valid);
      end
      step();
      checks++;
      if (a.piece_valid !== 1'b1 || a.piece_out !== 3'd6 ||
          a.count !== 4'd0) begin
         errors++;
         $display("FAIL er_grant got v=%b p=%0d c=%0d want 1 6 0",
                  a.piece_valid, a.piece_out, a.count);
      end
      a.gen_ready = 1'b1;
      a.gen_piece = 3'd3;
      step();
      a.gen_ready = 1'b0;
      step();
      checks++;
      if (a.piece_valid !== 1'b0 || a.count !== 4'd1) begin
         errors++;
         $display("FAIL er_single got v=%b c=%0d want v=0 c=1",
                  a.piece_valid, a.count);
      end
   endtask

   task automatic test_reset_in_wait();
      do_reset();
      a.req = 1'b1;
      step();
      a.req = 1'b0;
      step();
      #2;
      nreset = 1'b0;
      #1;
      checks++;
      if (a.count !== 4'd0 || a.piece_valid !== 1'b0) begin
         errors++;
         $display("FAIL rw_async got c=%0d v=%b want 0 0",
                  a.count, a.piece_valid);
      end
      @(negedge clk);
      nreset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (a.piece_valid !== 1'b0) begin
            errors++; $display("FAIL rw_quiet%0d got v=1 want 0", i);
         end
      end
      a.gen_ready = 1'b1;
      a.gen_piece = 3'd4;
      step();
      a.gen_ready = 1'b0;
      step();
      checks++;
      if (a.count !== 4'd1 || a.piece_valid !== 1'b0) begin
         errors++;
         $display("FAIL rw_idle got c=%0d v=%b want c=1 v=0",
                  a.count, a.piece_valid);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_full_push_pop();
      test_repeat();
      test_illegal();
      test_empty_req();
      test_reset_in_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
